// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux8_rr_arbiter
// Purpose  : Round-robin arbiter that owns the select of a 32-bit 8:1 mux and
//            runs a valid/ready handshake toward one consumer, acking the
//            served requester. Optional macro MUX8_ARB_GRANT_CNT_EN adds a
//            16-bit handshake counter output (xfer_count).
// Revision : 1.0
// ============================================================================
module mux8_rr_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  req,
  input  logic        out_ready,
  output logic [2:0]  sel,
  output logic [7:0]  grant,
  output logic        out_valid,
  output logic [7:0]  ack,
  output logic        timeout_err
`ifdef MUX8_ARB_GRANT_CNT_EN
  ,
  output logic [15:0] xfer_count
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit         C_TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] C_TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] grant_q, grant_d;
  logic       valid_q, valid_d;
  logic [7:0] ack_q, ack_d;
  logic       to_q, to_d;
  logic [2:0] last_q, last_d;
  logic [7:0] wcnt_q, wcnt_d;

  logic [3:0] pick_idle;
  logic [3:0] pick_rearb;
  logic       handshake;
  logic       expire;

  // Returns {found, index}; the search starts just after 'last' so that the
  // most recently served requester is visited last.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [3:0] res;
    logic [2:0] cand;
    res = 4'b0000;
    for (int i = 8; i >= 1; i--) begin
      cand = last + 3'(i);
      if (r[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  assign pick_idle  = rr_pick(req, last_q);
  assign pick_rearb = rr_pick(req, sel_q);
  assign handshake  = (state_q == GRANT) && out_ready;
  assign expire     = C_TO_EN && (state_q == GRANT) && !out_ready && (wcnt_q == C_TO_LAST);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ack_d   = 8'h00;
    to_d    = 1'b0;
    last_d  = last_q;
    wcnt_d  = wcnt_q;

    case (state_q)
      IDLE: begin
        if (pick_idle[3]) begin
          state_d = GRANT;
          sel_d   = pick_idle[2:0];
          grant_d = 8'b1 << pick_idle[2:0];
          valid_d = 1'b1;
          wcnt_d  = 8'd0;
        end
      end
      GRANT: begin
        if (handshake || expire) begin
          // Handshake takes precedence over an expiring grant.
          ack_d  = handshake ? grant_q : 8'h00;
          to_d   = !handshake;
          last_d = sel_q;
          if (pick_rearb[3]) begin
            sel_d   = pick_rearb[2:0];
            grant_d = 8'b1 << pick_rearb[2:0];
            valid_d = 1'b1;
            wcnt_d  = 8'd0;
          end else begin
            state_d = IDLE;
            grant_d = 8'h00;
            valid_d = 1'b0;
            wcnt_d  = 8'd0;
          end
        end else if (wcnt_q != 8'hFF) begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'h00;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      grant_q <= 8'h00;
      valid_q <= 1'b0;
      ack_q   <= 8'h00;
      to_q    <= 1'b0;
      last_q  <= 3'd7;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      to_q    <= to_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign sel         = sel_q;
  assign grant       = grant_q;
  assign out_valid   = valid_q;
  assign ack         = ack_q;
  assign timeout_err = to_q;

`ifdef MUX8_ARB_GRANT_CNT_EN
  logic [15:0] xcnt_q, xcnt_d;

  assign xcnt_d = handshake ? xcnt_q + 16'd1 : xcnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xcnt_q <= 16'd0;
    end else begin
      xcnt_q <= xcnt_d;
    end
  end

  assign xfer_count = xcnt_q;
`endif

endmodule
`default_nettype wire
